// File: rtl/plab4_net_router_input_ctrl_arb_rr_if.sv
// Handshake bundle between the per-domain input buffers, the switch arbiter
// and the domain-selecting input arbiter.
interface plab4_net_router_input_ctrl_arb_rr_if #(
  parameter int p_num_domains = 2,
  parameter int p_dest_nbits  = 3,
  parameter int p_dom_nbits   = 1
);
  logic [p_num_domains*p_dest_nbits-1:0] dest;
  logic [p_num_domains-1:0]              in_val;
  logic [p_num_domains-1:0]              in_rdy;
  logic [2:0]                            reqs;
  logic [2:0]                            grants;
  logic [p_dom_nbits-1:0]                domain;
  logic                                  domain_val;

  modport master (output dest, in_val, grants,
                  input  in_rdy, reqs, domain, domain_val);
  modport slave  (input  dest, in_val, grants,
                  output in_rdy, reqs, domain, domain_val);
endinterface

// File: rtl/plab4_net_router_input_ctrl_arb_rr.sv
// Multi-domain router input arbiter: one route-computing input ctrl per domain,
// one domain presented to the switch arbiter per cycle (round-robin+lock or TDM).
module plab4_net_RouterInputCtrl #(
  parameter int         p_router_id    = 0,
  parameter int         p_num_routers  = 8,
  parameter logic [2:0] p_default_reqs = 3'b001,
  localparam int        c_dest_nbits   = $clog2(p_num_routers)
)(
  input  logic [c_dest_nbits-1:0] dest,
  input  logic                    in_val,
  output logic [2:0]              reqs
);
  int fwd;
  always_comb begin
    fwd  = (int'(dest) - p_router_id + p_num_routers) % p_num_routers;
    reqs = 3'b000;
    if (in_val) begin
      if (fwd == 0)                   reqs = p_default_reqs;
      else if (fwd <= p_num_routers/2) reqs = 3'b100;
      else                             reqs = 3'b010;
    end
  end
endmodule

module plab4_net_router_input_ctrl_arb_rr #(
  parameter int         p_router_id    = 0,
  parameter int         p_num_routers  = 8,
  parameter int         p_num_domains  = 2,
  parameter logic [2:0] p_default_reqs = 3'b001,
  parameter int         p_mode         = 0,
  parameter int         p_slot_cycles  = 4,
  localparam int        c_dest_nbits   = $clog2(p_num_routers),
  localparam int        c_dom_nbits    = (p_num_domains > 1) ? $clog2(p_num_domains) : 1
)(
  input logic clk,
  input logic reset,
  plab4_net_router_input_ctrl_arb_rr_if.slave io
);
  typedef logic [c_dom_nbits-1:0] dom_t;

  function automatic dom_t dom_inc(dom_t x);
    return (x == dom_t'(p_num_domains-1)) ? '0 : x + 1'b1;
  endfunction

  logic [p_num_domains-1:0][2:0] reqs_d;
  logic [p_num_domains-1:0]      req_set;

  for (genvar g = 0; g < p_num_domains; g++) begin : g_dom
    plab4_net_RouterInputCtrl #(
      .p_router_id(p_router_id), .p_num_routers(p_num_routers),
      .p_default_reqs(p_default_reqs)
    ) u_ctrl (
      .dest  (io.dest[g*c_dest_nbits +: c_dest_nbits]),
      .in_val(io.in_val[g]),
      .reqs  (reqs_d[g])
    );
    assign req_set[g] = |reqs_d[g];
  end

  logic       sel_val;
  dom_t       sel;
  logic [2:0] reqs_sel;
  logic       act;
  logic       xfer;

  assign reqs_sel = reqs_d[sel];
  assign xfer     = sel_val & |(reqs_sel & io.grants);
  // Outputs are forced quiet during reset, independent of held state.
  assign act      = sel_val & ~reset;

  if (p_mode == 0) begin : g_rr
    dom_t ptr_q, ptr_d, lock_dom_q, lock_dom_d, scan_sel, idx;
    logic locked_q, locked_d, found, lock_hit;

    always_comb begin
      lock_hit = locked_q & req_set[lock_dom_q];
      found    = 1'b0;
      scan_sel = '0;
      idx      = ptr_q;
      for (int i = 0; i < p_num_domains; i++) begin
        if (!found && req_set[idx]) begin
          found    = 1'b1;
          scan_sel = idx;
        end
        idx = dom_inc(idx);
      end
      sel_val = lock_hit | found;
      sel     = lock_hit ? lock_dom_q : scan_sel;

      ptr_d      = ptr_q;
      locked_d   = 1'b0;
      lock_dom_d = lock_dom_q;
      // A grant always beats setting the lock; a stalled pick pins the selection.
      if (xfer) begin
        ptr_d = dom_inc(sel);
      end else if (sel_val) begin
        locked_d   = 1'b1;
        lock_dom_d = sel;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        ptr_q      <= '0;
        locked_q   <= 1'b0;
        lock_dom_q <= '0;
      end else begin
        ptr_q      <= ptr_d;
        locked_q   <= locked_d;
        lock_dom_q <= lock_dom_d;
      end
    end
  end else begin : g_tdm
    localparam int c_slot_nbits = (p_slot_cycles > 1) ? $clog2(p_slot_cycles) : 1;
    logic [c_slot_nbits-1:0] slot_cnt_q, slot_cnt_d;
    dom_t                    slot_dom_q, slot_dom_d;

    always_comb begin
      sel        = slot_dom_q;
      sel_val    = req_set[slot_dom_q];
      slot_cnt_d = slot_cnt_q + 1'b1;
      slot_dom_d = slot_dom_q;
      if (slot_cnt_q == c_slot_nbits'(p_slot_cycles-1)) begin
        slot_cnt_d = '0;
        slot_dom_d = dom_inc(slot_dom_q);
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        slot_cnt_q <= '0;
        slot_dom_q <= '0;
      end else begin
        slot_cnt_q <= slot_cnt_d;
        slot_dom_q <= slot_dom_d;
      end
    end
  end

  always_comb begin
    io.reqs       = act ? reqs_sel : 3'b000;
    io.domain     = act ? sel : '0;
    io.domain_val = act;
    for (int d = 0; d < p_num_domains; d++)
      io.in_rdy[d] = act && (sel == dom_t'(d)) && |(reqs_d[d] & io.grants);
  end
endmodule

// File: tb/tb_plab4_net_router_input_ctrl_arb_rr.sv
// Directed checks of round-robin/lock (N=2,4,3) and TDM (N=2) arbiter builds.
module tb_plab4_net_router_input_ctrl_arb_rr;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic ra = 1'b1, rb = 1'b1, rc = 1'b1, rd = 1'b1;
  int nvec = 0, nerr = 0;

  plab4_net_router_input_ctrl_arb_rr_if #(.p_num_domains(2), .p_dest_nbits(3), .p_dom_nbits(1)) ia ();
  plab4_net_router_input_ctrl_arb_rr_if #(.p_num_domains(4), .p_dest_nbits(3), .p_dom_nbits(2)) ib ();
  plab4_net_router_input_ctrl_arb_rr_if #(.p_num_domains(3), .p_dest_nbits(3), .p_dom_nbits(2)) ic ();
  plab4_net_router_input_ctrl_arb_rr_if #(.p_num_domains(2), .p_dest_nbits(3), .p_dom_nbits(1)) id ();

  plab4_net_router_input_ctrl_arb_rr #(.p_num_domains(2), .p_mode(0)) dut_a (.clk(clk), .reset(ra), .io(ia));
  plab4_net_router_input_ctrl_arb_rr #(.p_num_domains(4), .p_mode(0)) dut_b (.clk(clk), .reset(rb), .io(ib));
  plab4_net_router_input_ctrl_arb_rr #(.p_num_domains(3), .p_mode(0)) dut_c (.clk(clk), .reset(rc), .io(ic));
  plab4_net_router_input_ctrl_arb_rr #(.p_num_domains(2), .p_mode(1), .p_slot_cycles(4)) dut_d (.clk(clk), .reset(rd), .io(id));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    ia.dest = '0; ia.in_val = '0; ia.grants = '0;
    ib.dest = '0; ib.in_val = '0; ib.grants = '0;
    ic.dest = '0; ic.in_val = '0; ic.grants = '0;
    id.dest = '0; id.in_val = '0; id.grants = '0;
    step(); step();

    // reset state with requests present
    ia.in_val = 2'b11; ia.grants = 3'b001; #1;
    chk("rst_a_val",  8'(ia.domain_val), 8'd0);
    chk("rst_a_rdy",  8'(ia.in_rdy),     8'd0);
    chk("rst_a_reqs", 8'(ia.reqs),       8'd0);
    step();

    // A: alternation under continuous grants
    ra = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("a_alt_dom",  8'(ia.domain), 8'(c % 2));
      chk("a_alt_reqs", 8'(ia.reqs),   8'h01);
      chk("a_alt_rdy",  8'(ia.in_rdy), (c % 2) ? 8'h02 : 8'h01);
      step();
    end

    // A: mismatched grant -> no dequeue, selection held
    ia.grants = 3'b010; #1;
    chk("a_mis_rdy", 8'(ia.in_rdy),     8'd0);
    chk("a_mis_val", 8'(ia.domain_val), 8'd1);
    chk("a_mis_dom", 8'(ia.domain),     8'd0);
    step(); #1;
    chk("a_mis_dom2", 8'(ia.domain), 8'd0);
    chk("a_mis_rdy2", 8'(ia.in_rdy), 8'd0);
    step();

    // A: lock onto domain 1, then domain 0 joins but lock holds
    ia.in_val = 2'b10; ia.grants = 3'b000; #1;
    chk("a_lk_dom", 8'(ia.domain), 8'd1);
    step();
    ia.in_val = 2'b11; #1;
    chk("a_lk_hold", 8'(ia.domain), 8'd1);
    step();

    // A: reset while locked
    ra = 1'b1; ia.grants = 3'b001; #1;
    chk("a_rst_rdy",  8'(ia.in_rdy),     8'd0);
    chk("a_rst_val",  8'(ia.domain_val), 8'd0);
    chk("a_rst_reqs", 8'(ia.reqs),       8'd0);
    step(); step();
    ra = 1'b0; #1;
    chk("a_post_dom", 8'(ia.domain), 8'd0);
    chk("a_post_rdy", 8'(ia.in_rdy), 8'h01);
    step();

    // B: N=4, domain 2 locked through a 3-cycle grant stall
    rb = 1'b0; ib.in_val = 4'b0100; #1;
    chk("b_c0_dom", 8'(ib.domain), 8'd2);
    chk("b_c0_rdy", 8'(ib.in_rdy), 8'd0);
    step();
    ib.in_val = 4'b0101; #1;
    chk("b_c1_dom", 8'(ib.domain), 8'd2);
    step(); #1;
    chk("b_c2_dom", 8'(ib.domain), 8'd2);
    step();
    ib.grants = 3'b001; #1;
    chk("b_c3_dom", 8'(ib.domain), 8'd2);
    chk("b_c3_rdy", 8'(ib.in_rdy), 8'h04);
    step();
    ib.grants = 3'b000; #1;
    chk("b_c4_dom", 8'(ib.domain),     8'd0);
    chk("b_c4_val", 8'(ib.domain_val), 8'd1);
    step();

    // C: N=3, move ptr to 2, then wrap scan picks 0 then 1
    rc = 1'b0; ic.in_val = 3'b010; ic.grants = 3'b001; #1;
    chk("c_pre_dom", 8'(ic.domain), 8'd1);
    chk("c_pre_rdy", 8'(ic.in_rdy), 8'h02);
    step();
    ic.in_val = 3'b011; #1;
    chk("c_wrap_dom0", 8'(ic.domain), 8'd0);
    chk("c_wrap_rdy0", 8'(ic.in_rdy), 8'h01);
    step(); #1;
    chk("c_wrap_dom1", 8'(ic.domain), 8'd1);
    chk("c_wrap_rdy1", 8'(ic.in_rdy), 8'h02);
    step();

    // D: TDM, only domain 1 requests; it is served only in its slot
    rd = 1'b0; id.in_val = 2'b10; id.grants = 3'b001;
    for (int c = 0; c < 12; c++) begin
      #1;
      chk("d_tdm_val", 8'(id.domain_val), (c >= 4 && c < 8) ? 8'd1 : 8'd0);
      chk("d_tdm_rdy", 8'(id.in_rdy),     (c >= 4 && c < 8) ? 8'h02 : 8'h00);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
